// File: rtl/bcd2_seg_scan_pkg.sv
// Shared types and constants for the two-digit BCD seven-segment scanner.
package bcd2_seg_scan_pkg;

  // Scan FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TENS  = 3'd1,
    ST_GAP_T = 3'd2,
    ST_ONES  = 3'd3,
    ST_GAP_O = 3'd4
  } scan_state_e;

  // Active-high segment glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd2_seg_scan_if.sv
// Capture inputs and display pins of the BCD seven-segment scanner.
interface bcd2_seg_scan_if;
  logic       load;
  logic [7:0] sum_in;
  logic       of_in;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;

  modport master (output load, sum_in, of_in, input seg, dp, an);
  modport slave  (input load, sum_in, of_in, output seg, dp, an);
endinterface

// File: rtl/bcd2_seg_scan_decode.sv
// Nibble to active-high seven-segment glyph; non-BCD nibbles show a dash.
module bcd_seg_decode
  import bcd2_seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  // Glyph lookup table.
  always_comb begin
    glyph_o = SEG_DASH;
    case (nib_i)
      4'd0:    glyph_o = SEG_0;
      4'd1:    glyph_o = SEG_1;
      4'd2:    glyph_o = SEG_2;
      4'd3:    glyph_o = SEG_3;
      4'd4:    glyph_o = SEG_4;
      4'd5:    glyph_o = SEG_5;
      4'd6:    glyph_o = SEG_6;
      4'd7:    glyph_o = SEG_7;
      4'd8:    glyph_o = SEG_8;
      4'd9:    glyph_o = SEG_9;
      default: glyph_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd2_seg_scan.sv
// Two-digit multiplexed seven-segment driver for a packed BCD sum with
// anti-ghost gaps, leading-zero blanking and overflow blinking.
module bcd2_seg_scan
  import bcd2_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  bcd2_seg_scan_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  // XOR masks that turn active-high "on" levels into pin levels.
  localparam logic [6:0] INV7 = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] INV2 = ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic       INV1 = ACTIVE_LOW ? 1'b1 : 1'b0;

  scan_state_e   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [7:0]    sum_q;
  logic          of_q, valid_q;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    an_q, an_d;
  logic [3:0]    digit_s;
  logic [6:0]    glyph_s;

  // Capture register: every load replaces the displayed value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= 8'h00;
      of_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.load) begin
      sum_q   <= bus.sum_in;
      of_q    <= bus.of_in;
      valid_q <= 1'b1;
    end
  end

  // Scan FSM and dwell prescaler; the prescaler restarts on every state change.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_d = ST_TENS;
          presc_d = {PW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TENS: begin
        if (presc_q == PRE_LAST) begin
          state_d = ST_GAP_T;
          presc_d = {PW{1'b0}};
        end else begin
          presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP_T: begin
        state_d = ST_ONES;
        presc_d = {PW{1'b0}};
      end
      ST_ONES: begin
        if (presc_q == PRE_LAST) begin
          state_d = ST_GAP_O;
          presc_d = {PW{1'b0}};
        end else begin
          presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP_O: begin
        state_d = ST_TENS;
        presc_d = {PW{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = {PW{1'b0}};
      end
    endcase
  end

  // Blink phase: counts full scans at GAP_O->TENS; a fresh overflow restarts
  // at on-phase and no overflow pins it on.
  always_comb begin
    blink_on_d  = blink_on_q;
    blink_cnt_d = blink_cnt_q;
    if (bus.load && bus.of_in && !of_q) begin
      blink_on_d  = 1'b1;
      blink_cnt_d = {BW{1'b0}};
    end else if (!of_q) begin
      blink_on_d  = 1'b1;
      blink_cnt_d = {BW{1'b0}};
    end else if (state_q == ST_GAP_O) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BW{1'b0}};
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      blink_on_d  = blink_on_q;
      blink_cnt_d = blink_cnt_q;
    end
  end

  // State, prescaler and blink registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= {PW{1'b0}};
      blink_on_q  <= 1'b1;
      blink_cnt_q <= {BW{1'b0}};
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign digit_s = (state_q == ST_ONES) ? sum_q[3:0] : sum_q[7:4];

  bcd_seg_decode u_decode (
    .nib_i   (digit_s),
    .glyph_o (glyph_s)
  );

  // Next pin levels from the current state: active-high first, then polarity.
  always_comb begin
    logic [6:0] seg_on;
    logic       dp_on;
    logic [1:0] an_on;
    seg_on = SEG_OFF;
    dp_on  = 1'b0;
    an_on  = 2'b00;
    case (state_q)
      ST_TENS: begin
        if (valid_q && blink_on_q && ((sum_q[7:4] != 4'd0) || of_q)) begin
          seg_on = glyph_s;
          an_on  = 2'b10;
          dp_on  = of_q;
        end else begin
          seg_on = SEG_OFF;
        end
      end
      ST_ONES: begin
        if (valid_q && blink_on_q) begin
          seg_on = glyph_s;
          an_on  = 2'b01;
        end else begin
          seg_on = SEG_OFF;
        end
      end
      default: seg_on = SEG_OFF;
    endcase
    seg_d = seg_on ^ INV7;
    dp_d  = dp_on ^ INV1;
    an_d  = an_on ^ INV2;
  end

  // Registered display pins; reset drives everything off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= INV7;
      dp_q  <= INV1;
      an_q  <= INV2;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_bcd2_seg_scan.sv
// Directed bench for bcd2_seg_scan with SCAN_DIV=4, BLINK_DIV=2, active-low pins.
module tb_bcd2_seg_scan;

  localparam logic [6:0] S_OFF  = 7'h7F;
  localparam logic [6:0] S4     = 7'b0011001;
  localparam logic [6:0] S2     = 7'b0100100;
  localparam logic [6:0] S7     = 7'b1111000;
  localparam logic [6:0] S3     = 7'b0110000;
  localparam logic [6:0] S5     = 7'b0010010;
  localparam logic [6:0] S9     = 7'b0010000;
  localparam logic [6:0] S_DASH = 7'b0111111;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bcd2_seg_scan_if bus ();

  bcd2_seg_scan #(
    .SCAN_DIV   (4),
    .BLINK_DIV  (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [6:0] es, input logic edp,
                       input logic [1:0] ea);
    vectors++;
    assert ({bus.seg, bus.dp, bus.an} === {es, edp, ea})
    else begin
      miscompares++;
      $error("FAIL %s: seg=%b dp=%b an=%b, expected seg=%b dp=%b an=%b",
             tag, bus.seg, bus.dp, bus.an, es, edp, ea);
    end
  endtask

  task automatic check_off(input string tag);
    check(tag, S_OFF, 1'b1, 2'b11);
  endtask

  // Present one load at the next edge; returns at the negedge after it.
  task automatic load_val(input logic [7:0] s, input logic o);
    bus.load   = 1'b1;
    bus.sum_in = s;
    bus.of_in  = o;
    tick();
    bus.load   = 1'b0;
  endtask

  // nt tens cycles, tens gap, no ones cycles, ones gap only if the dwell is full.
  task automatic check_scan(input string tag, input int nt, input int no,
                            input logic [6:0] t_seg, input logic t_dp,
                            input logic [1:0] t_an, input logic [6:0] o_seg,
                            input logic [1:0] o_an);
    for (int i = 0; i < nt; i++) begin
      tick();
      check({tag, "_tens"}, t_seg, t_dp, t_an);
    end
    tick();
    check_off({tag, "_gapt"});
    for (int i = 0; i < no; i++) begin
      tick();
      check({tag, "_ones"}, o_seg, 1'b1, o_an);
    end
    if (no == 4) begin
      tick();
      check_off({tag, "_gapo"});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.load    = 1'b0;
    bus.sum_in  = 8'h00;
    bus.of_in   = 1'b0;
    rst_n       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Idle after reset: everything off.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_off("idle");
    end

    // 42 from idle: tens first two cycles after the load, 10-cycle period.
    load_val(8'h42, 1'b0);
    check_off("ld42");
    check_scan("s42a", 4, 4, S4, 1'b1, 2'b01, S2, 2'b10);
    check_scan("s42b", 4, 4, S4, 1'b1, 2'b01, S2, 2'b10);

    // Load 07 at the start of a tens dwell: one old cycle, then blanked tens.
    load_val(8'h07, 1'b0);
    check("mid_old", S4, 1'b1, 2'b01);
    check_scan("s07a", 3, 4, S_OFF, 1'b1, 2'b11, S7, 2'b10);
    check_scan("s07b", 4, 4, S_OFF, 1'b1, 2'b11, S7, 2'b10);

    // Invalid tens nibble shows a dash.
    do_reset();
    load_val(8'hA9, 1'b0);
    check_off("ldA9");
    check_scan("sA9", 4, 4, S_DASH, 1'b1, 2'b01, S9, 2'b10);
    check_scan("sA9r", 4, 2, S_DASH, 1'b1, 2'b01, S9, 2'b10);

    // One-cycle reset during ONES blanks until a new load.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_off("rst_mid");
    for (int i = 0; i < 5; i++) begin
      tick();
      check_off("rst_idle");
    end
    load_val(8'h42, 1'b0);
    check_off("ld42r");
    check_scan("s42r", 4, 4, S4, 1'b1, 2'b01, S2, 2'b10);

    // Overflow: dp in tens, 2 scans on, 2 scans off; repeat load keeps phase.
    do_reset();
    load_val(8'h35, 1'b1);
    check_off("ld35");
    check_scan("s35a", 4, 4, S3, 1'b0, 2'b01, S5, 2'b10);
    check_scan("s35b", 4, 4, S3, 1'b0, 2'b01, S5, 2'b10);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_off("blink_off");
    end
    load_val(8'h35, 1'b1);
    check_off("blink_reld");
    for (int i = 0; i < 9; i++) begin
      tick();
      check_off("blink_off2");
    end
    check_scan("s35on", 4, 4, S3, 1'b0, 2'b01, S5, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
